// File: rtl/pulp_clock_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package pulp_clock_pkg;

  localparam int unsigned DIV_W_DEF  = 8;
  localparam int unsigned BYPASS_MAX = 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PARK   = 2'd1,
    ST_BYPASS = 2'd2
  } div_state_e;

  // Source cycles spent high in one output period of ratio n.
  function automatic int unsigned hi_cycles(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/pulp_clock_divider_if.sv
// Ratio request handshake and status between a controller and the clock divider.
interface pulp_clock_divider_if #(
  parameter int unsigned DIV_W = 8
);

  logic [DIV_W-1:0] div_i;
  logic             div_valid_i;
  logic             div_ready_o;
  logic [DIV_W-1:0] div_active_o;

  modport master (
    output div_i,
    output div_valid_i,
    input  div_ready_o,
    input  div_active_o
  );

  modport slave (
    input  div_i,
    input  div_valid_i,
    output div_ready_o,
    output div_active_o
  );

endinterface

// File: rtl/pulp_clock_div_core.sv
// Divider core: period counter, registered divided clock and the one-deep ratio request slot.
//   state     | meaning
//   ST_RUN    | counting 0..N-1, div_q high for the first ceil(N/2) counts
//   ST_PARK   | output held low at a period boundary, waiting for en_i
//   ST_BYPASS | ratio 0/1 in effect, top level routes clk_i straight out
module pulp_clock_div_core
  import pulp_clock_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic [DIV_W-1:0] div_active_o,
  output logic             div_o,
  output logic             bypass_o
);

  localparam logic [DIV_W-1:0] DefDiv    = DIV_W'(DEFAULT_DIV);
  localparam logic             DefBypass = (DEFAULT_DIV <= BYPASS_MAX);
  localparam logic [DIV_W-1:0] One       = DIV_W'(1);

  div_state_e       state_q,    state_d;
  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic             div_q,      div_d;
  logic [DIV_W-1:0] active_q,   active_d;
  logic [DIV_W-1:0] pend_q,     pend_d;
  logic             pend_vld_q, pend_vld_d;

  logic             accept;
  logic             at_bnd;
  logic [DIV_W-1:0] next_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= DefBypass ? ST_BYPASS : ST_PARK;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      active_q   <= DefDiv;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    accept = div_valid_i & ~pend_vld_q;
    next_n = pend_vld_q ? pend_q : active_q;
    // Parked and bypass states behave as a permanent period boundary.
    at_bnd = (state_q != ST_RUN) || (cnt_q == (active_q - One));

    if (at_bnd) begin
      if (pend_vld_q) begin
        active_d   = pend_q;
        pend_vld_d = 1'b0;
      end
      if (32'(next_n) <= BYPASS_MAX) begin
        state_d = ST_BYPASS;
        cnt_d   = '0;
        div_d   = 1'b0;
      end else if ((state_q == ST_BYPASS) || !en_i) begin
        // Leaving bypass parks for one cycle so the output mux swaps while div_q is low.
        state_d = ST_PARK;
        cnt_d   = next_n - One;
        div_d   = 1'b0;
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
        div_d   = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + One;
      div_d = (32'(cnt_d) < hi_cycles(32'(active_q)));
    end

    if (accept) begin
      pend_d     = div_i;
      pend_vld_d = 1'b1;
    end
  end

  assign div_ready_o  = ~pend_vld_q;
  assign div_active_o = active_q;
  assign div_o        = div_q;
  assign bypass_o     = (state_q == ST_BYPASS);

endmodule

// File: rtl/pulp_clock_gate.sv
// Clock gate cell: enable is captured while clk_i is low so the gated clock never chops a high phase.
module pulp_clock_gate (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic clk_o
);

  logic en_d;
  logic en_q;

  always_comb begin
    en_d = en_i;
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b1;
    end else begin
      en_q <= en_d;
    end
  end

  assign clk_o = clk_i & en_q;

endmodule

// File: rtl/pulp_clock_mux2.sv
// Two-input clock multiplexer cell; callers only switch it while both inputs are low.
module pulp_clock_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);

  assign clk_o = sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/pulp_clock_divider.sv
// Programmable integer clock divider with bypass, output enable and DFT pass-through.
module pulp_clock_divider
  import pulp_clock_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  input  logic                  en_i,
  pulp_clock_divider_if.slave   bus,
  output logic                  clk_o
);

  localparam logic DefBypass = (DEFAULT_DIV <= BYPASS_MAX);

  logic div_clk;
  logic bypass;
  logic clk_gated;
  logic clk_sel;
  logic sel_d;
  logic sel_q;

  pulp_clock_div_core #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .div_i        (bus.div_i),
    .div_valid_i  (bus.div_valid_i),
    .div_ready_o  (bus.div_ready_o),
    .div_active_o (bus.div_active_o),
    .div_o        (div_clk),
    .bypass_o     (bypass)
  );

  pulp_clock_gate u_gate (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .clk_o  (clk_gated)
  );

  always_comb begin
    sel_d = bypass;
  end

  // Falling-edge select: clk_i is low here and the core keeps div_q low around a swap.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= DefBypass;
    end else begin
      sel_q <= sel_d;
    end
  end

  pulp_clock_mux2 u_bypass_mux (
    .clk0_i (div_clk),
    .clk1_i (clk_gated),
    .sel_i  (sel_q),
    .clk_o  (clk_sel)
  );

  pulp_clock_mux2 u_test_mux (
    .clk0_i (clk_sel),
    .clk1_i (clk_i),
    .sel_i  (test_mode_i),
    .clk_o  (clk_o)
  );

endmodule

// File: tb/tb_pulp_clock_divider.sv
// Directed bench for pulp_clock_divider with DEFAULT_DIV=4; clk_o is sampled 1 unit after clk_i rises.
module tb_pulp_clock_divider;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic test_mode = 1'b0;
  logic en        = 1'b1;
  logic clk_o;

  int errors = 0;
  int checks = 0;

  bit      glitch_chk = 1'b0;
  realtime last_edge  = 0.0;

  pulp_clock_divider_if #(.DIV_W(8)) bus ();

  pulp_clock_divider #(
    .DIV_W       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .en_i        (en),
    .bus         (bus),
    .clk_o       (clk_o)
  );

  always #5 clk = ~clk;

  // Any clk_o phase shorter than half a clk_i period is a glitch.
  always @(clk_o) begin
    if (glitch_chk) begin
      checks++;
      if (($realtime - last_edge) < 5.0) begin
        errors++;
        $display("FAIL glitch: phase width %0t, required at least 5", $realtime - last_edge);
      end
      last_edge = $realtime;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shift in one clk_o sample per cycle; the first sample ends up as the MSB.
  task automatic capture(input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      step(1);
      v = {v[30:0], clk_o};
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (bus.div_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic request(input logic [7:0] d);
    bus.div_i       = d;
    bus.div_valid_i = 1'b1;
    step(1);
    bus.div_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    step(3);
    checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b expected 0", clk_o); end
    checks++; if (bus.div_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.div_ready_o); end
    checks++; if (bus.div_active_o !== 8'd4) begin errors++; $display("FAIL rst_active: got %0d expected 4", bus.div_active_o); end
    rst_n = 1'b1;
    last_edge  = $realtime;
    glitch_chk = 1'b1;
    capture(8, v);
    checks++; if (v[7:0] !== 8'b11001100) begin errors++; $display("FAIL div4_wave: got %b expected 11001100", v[7:0]); end
    checks++; if (bus.div_ready_o !== 1'b1) begin errors++; $display("FAIL div4_ready: got %b expected 1", bus.div_ready_o); end
    checks++; if (bus.div_active_o !== 8'd4) begin errors++; $display("FAIL div4_active: got %0d expected 4", bus.div_active_o); end
  endtask

  task automatic test_change_ratio();
    logic [31:0] v;
    step(2);
    checks++; if (clk_o !== 1'b1) begin errors++; $display("FAIL mid_high: got %b expected 1", clk_o); end
    request(8'd3);
    checks++; if (bus.div_ready_o !== 1'b0) begin errors++; $display("FAIL req3_ready_drop: got %b expected 0", bus.div_ready_o); end
    checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL req3_low1: got %b expected 0", clk_o); end
    step(1);
    checks++; if ({bus.div_ready_o, clk_o} !== 2'b00) begin errors++; $display("FAIL req3_bnd: got ready/clk %b expected 00", {bus.div_ready_o, clk_o}); end
    step(1);
    checks++; if ({bus.div_ready_o, clk_o} !== 2'b11) begin errors++; $display("FAIL req3_applied: got ready/clk %b expected 11", {bus.div_ready_o, clk_o}); end
    checks++; if (bus.div_active_o !== 8'd3) begin errors++; $display("FAIL req3_active: got %0d expected 3", bus.div_active_o); end
    capture(6, v);
    checks++; if (v[5:0] !== 6'b101101) begin errors++; $display("FAIL div3_wave: got %b expected 101101", v[5:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] v;
    bit ok;
    request(8'd5);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL req5_timeout: got no ready expected ready"); end
    checks++; if (bus.div_active_o !== 8'd5) begin errors++; $display("FAIL req5_active: got %0d expected 5", bus.div_active_o); end
    capture(5, v);
    checks++; if (v[4:0] !== 5'b11001) begin errors++; $display("FAIL div5_wave: got %b expected 11001", v[4:0]); end
    request(8'd1);
    capture(4, v);
    checks++; if (v[3:0] !== 4'b1000) begin errors++; $display("FAIL enter_bypass_wave: got %b expected 1000", v[3:0]); end
    checks++; if (bus.div_active_o !== 8'd1) begin errors++; $display("FAIL req1_active: got %0d expected 1", bus.div_active_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL bypass_low: got %b expected 0", clk_o); end
      @(posedge clk); #1;
      checks++; if (clk_o !== 1'b1) begin errors++; $display("FAIL bypass_high: got %b expected 1", clk_o); end
    end
    en = 1'b0;
    step(1);
    checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL bypass_gated: got %b expected 0", clk_o); end
    en = 1'b1;
    step(1);
    checks++; if (clk_o !== 1'b1) begin errors++; $display("FAIL bypass_ungated: got %b expected 1", clk_o); end
    request(8'd2);
    step(1);
    checks++; if (bus.div_ready_o !== 1'b1) begin errors++; $display("FAIL leave_bypass_ready: got %b expected 1", bus.div_ready_o); end
    checks++; if (bus.div_active_o !== 8'd2) begin errors++; $display("FAIL req2_active: got %0d expected 2", bus.div_active_o); end
    capture(6, v);
    checks++; if (v[5:0] !== 6'b101010) begin errors++; $display("FAIL div2_wave: got %b expected 101010", v[5:0]); end
  endtask

  task automatic test_enable();
    logic [31:0] v;
    bit ok;
    request(8'd6);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL req6_timeout: got no ready expected ready"); end
    checks++; if (bus.div_active_o !== 8'd6) begin errors++; $display("FAIL req6_active: got %0d expected 6", bus.div_active_o); end
    step(1);
    en = 1'b0;
    capture(8, v);
    checks++; if (v[7:0] !== 8'b10000000) begin errors++; $display("FAIL park_wave: got %b expected 10000000", v[7:0]); end
    en = 1'b1;
    capture(6, v);
    checks++; if (v[5:0] !== 6'b111000) begin errors++; $display("FAIL resume_wave: got %b expected 111000", v[5:0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    bit ok;
    bus.div_i       = 8'd7;
    bus.div_valid_i = 1'b1;
    step(1);
    bus.div_i = 8'd2;
    checks++; if (bus.div_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", bus.div_ready_o); end
    checks++; if (bus.div_active_o !== 8'd6) begin errors++; $display("FAIL b2b_not_same_bnd: got %0d expected 6", bus.div_active_o); end
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no ready expected ready"); end
    checks++; if (bus.div_active_o !== 8'd7) begin errors++; $display("FAIL b2b_active7: got %0d expected 7", bus.div_active_o); end
    checks++; if (clk_o !== 1'b1) begin errors++; $display("FAIL b2b_first_high: got %b expected 1", clk_o); end
    step(1);
    bus.div_valid_i = 1'b0;
    checks++; if (bus.div_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b expected 0", bus.div_ready_o); end
    capture(7, v);
    checks++; if (v[6:0] !== 7'b1100010) begin errors++; $display("FAIL b2b_wave: got %b expected 1100010", v[6:0]); end
    checks++; if (bus.div_active_o !== 8'd2) begin errors++; $display("FAIL b2b_active2: got %0d expected 2", bus.div_active_o); end
    checks++; if (bus.div_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", bus.div_ready_o); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    bit ok;
    request(8'd8);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL req8_timeout: got no ready expected ready"); end
    checks++; if (bus.div_active_o !== 8'd8) begin errors++; $display("FAIL req8_active: got %0d expected 8", bus.div_active_o); end
    request(8'd3);
    checks++; if ({bus.div_ready_o, clk_o} !== 2'b01) begin errors++; $display("FAIL pre_rst: got ready/clk %b expected 01", {bus.div_ready_o, clk_o}); end
    glitch_chk = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL async_drop: got %b expected 0", clk_o); end
    checks++; if (bus.div_active_o !== 8'd4) begin errors++; $display("FAIL rst_active_default: got %0d expected 4", bus.div_active_o); end
    step(2);
    rst_n = 1'b1;
    capture(8, v);
    checks++; if (v[7:0] !== 8'b11001100) begin errors++; $display("FAIL post_rst_wave: got %b expected 11001100", v[7:0]); end
    checks++; if (bus.div_active_o !== 8'd4) begin errors++; $display("FAIL pending_lost: got %0d expected 4", bus.div_active_o); end
    checks++; if (bus.div_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", bus.div_ready_o); end
  endtask

  task automatic test_test_mode();
    logic [31:0] v;
    test_mode = 1'b1;
    #1;
    checks++; if (clk_o !== 1'b1) begin errors++; $display("FAIL tm_override: got %b expected 1", clk_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL tm_low: got %b expected 0", clk_o); end
      @(posedge clk); #1;
      checks++; if (clk_o !== 1'b1) begin errors++; $display("FAIL tm_high: got %b expected 1", clk_o); end
    end
    test_mode = 1'b0;
    #1;
    checks++; if (clk_o !== 1'b1) begin errors++; $display("FAIL tm_release: got %b expected 1", clk_o); end
    capture(4, v);
    checks++; if (v[3:0] !== 4'b0011) begin errors++; $display("FAIL tm_state_kept: got %b expected 0011", v[3:0]); end
  endtask

  initial begin
    bus.div_i       = 8'd0;
    bus.div_valid_i = 1'b0;
    test_reset();
    test_change_ratio();
    test_bypass();
    test_enable();
    test_back_to_back();
    test_async_reset();
    test_test_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulp_clock_divider.md
Name: pulp_clock_divider

Overview:
- Programmable integer clock divider for SoC peripheral and debug clock domains; one source clock in, one derived clock out.
- Supports divide ratios 2..2^DIV_W-1, a bypass mode (ratio 0 or 1), and an output enable.
- Ratio changes use a valid/ready handshake and take effect only at an output-period boundary, so the output never produces a truncated or glitched pulse.
- Test mode forces a direct pass-through of the source clock for DFT.

Parameters:
- DIV_W, 8, width of the ratio field.
- DEFAULT_DIV, 2, active ratio after reset; must be < 2^DIV_W.

Ports:
- clk_i  input  1  source clock.
- rst_ni  input  1  asynchronous active-low reset.
- test_mode_i  input  1  1 = clk_o is clk_i, combinational; overrides everything else.
- en_i  input  1  output enable; 0 = park clk_o low at the next period boundary.
- div_i  input  DIV_W  requested ratio.
- div_valid_i  input  1  ratio request valid.
- div_ready_o  output  1  block can accept a ratio request.
- div_active_o  output  DIV_W  ratio currently in effect.
- clk_o  output  1  divided clock.

Behaviour:
- Reset values (async, rst_ni=0):
  - cnt_q=0, div_q=0, active=DEFAULT_DIV, pending flag=0, div_ready_o=1.
  - bypass_q=(DEFAULT_DIV<=1).
  - clk_o=0 immediately, unless test_mode_i=1 or bypass_q=1, in which case clk_o=clk_i.
- Counting mode (bypass_q=0, en_i=1):
  - cnt_q counts 0..N-1 and wraps, where N=active.
  - div_q is registered: next div_q = (next cnt < ceil(N/2)).
  - clk_o=div_q, giving a high phase of ceil(N/2) and a low phase of floor(N/2) source cycles. N=2 yields a 50% clock; N=3 yields high 2, low 1.
  - The first rising edge of clk_o appears 1 cycle after reset deassertion.
- Period boundary: the cycle in which cnt_q==N-1 (div_q low). Pending ratio changes, bypass entry and enable changes are applied only here.
- Handshake:
  - A request is accepted when div_valid_i & div_ready_o; div_i is captured into pending_q and div_ready_o drops the next cycle.
  - At the next boundary: active<=pending_q, cnt_q<=0, pending cleared, div_ready_o=1 the following cycle.
  - Exactly one request is outstanding; further valid requests stall until ready returns.
  - Writing the same ratio as active is still a full handshake.
- Bypass:
  - Pending ratio 0 or 1 sets bypass_q at the boundary.
  - Output selection goes through pulp_clock_mux2 with a select register updated on the falling edge of clk_i, so the switch happens while both clk_i and div_q are low.
  - Leaving bypass (new ratio >=2) is accepted any cycle. The switch is applied on the next clk_i falling edge, and counting restarts at cnt 0.
- Enable:
  - en_i=0 seen during a period: the period completes, then cnt_q holds at N-1 with clk_o low.
  - en_i=1 resumes with cnt 0 on the next cycle.
  - In bypass, en_i=0 gates clk_o low via a clock-gate cell enabled on clk_i low phase.
  - Handshakes still complete while disabled; a pending change is applied at the next boundary, i.e. immediately while parked.
- Simultaneous events:
  - A request accepted in a boundary cycle is applied at the following boundary, not the current one.
  - en_i falling in the same boundary cycle as a pending apply: the apply happens first, then the block parks.
- Reset mid-period: clk_o drops asynchronously and any pending request is discarded.
- test_mode_i: pure combinational override; internal state keeps running and is unaffected.

Decomposition:
- pulp_clock_pkg holds:
  - the DIV_W default;
  - constant BYPASS_MAX=1;
  - a helper function hi_cycles(N)=ceil(N/2).
- One sub-module, pulp_clock_div_core: counter, div_q, pending/handshake logic.
- The top level instantiates the core, pulp_clock_mux2 (bypass select), a clock-gate cell and the test-mode mux.

Test Plan:
- Reset with DEFAULT_DIV=4 -> clk_o low during reset; after release clk_o period is 4 clk_i cycles, high 2 / low 2; div_ready_o=1, div_active_o=4.
- Request div=3 mid-period with valid held 1 cycle -> ready low next cycle; the current 4-period completes intact; the next period is high 2 / low 1; ready returns 1 cycle after the boundary; div_active_o=3.
- Request div=1 while running at 5 -> the current period completes; clk_o then equals clk_i with no pulse shorter than half a clk_i period. Then request div=2 -> a clean 50% clock at half frequency.
- en_i=0 asserted at cnt=1 of a div=6 period -> 3 high + 3 low completes, then clk_o stays low. en_i=1 -> the first rising edge comes 1 cycle later.
- Back-to-back valid requests (7 then 2) -> the second stalls with ready low until the 7 is applied; both are applied at successive boundaries.
- Async rst_ni pulse while clk_o is high at div=8 with a request pending -> clk_o drops immediately; after release the ratio is DEFAULT_DIV and the pending request is lost. test_mode_i=1 at any point -> clk_o follows clk_i.
